serial_add_ctrl: RTL and testbench

Bit-serial adder controller: accepts two WIDTH-bit operands plus carry-in over a valid/ready handshake and sequences a single internal full-adder bit cell (one `halfadd` pair plus an OR on the carries) across the operands LSB-first, one bit per clock. It owns the carry flip-flop, operand shift registers, bit counter and result register, and presents the WIDTH-bit sum and carry-out over a second valid/ready handshake. It is the time-multiplexed, area-minimal alternative to a WIDTH-wide ripple adder built from full-adder cells.

---
 rtl/serial_add_ctrl.sv | 118 +++++++++++
 tb/tb_serial_add_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: a single full-adder cell (two halfadd + OR) stepped LSB-first over WIDTH cycles.
// Optional subtract support is compiled in with SERIAL_ADD_SUB_EN (adds the sub port).

module halfadd (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

// state | meaning
// IDLE  | waiting for operands, in_ready high (outside reset)
// RUN   | one sum bit per cycle, cnt = bits already produced
// DONE  | sum/cout presented with out_valid, waiting for out_ready
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef SERIAL_ADD_SUB_EN
    ,
    input  logic             sub
`endif
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;
    logic             p_bit;
    logic             g_bit;
    logic             s_bit;
    logic             t_bit;
    logic             c_bit;

    halfadd u_ha0 (.x(a_sh[0]), .y(b_sh[0]), .s(p_bit), .c(g_bit));
    halfadd u_ha1 (.x(p_bit),   .y(carry),   .s(s_bit), .c(t_bit));
    assign c_bit = g_bit | t_bit;

`ifdef SERIAL_ADD_SUB_EN
    // a - b computed as a + ~b + 1; cout then means "no borrow"
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub ? 1'b1 : cin;
`else
    assign b_load     = b;
    assign carry_load = cin;
`endif

    // rst gates in_ready so nothing is accepted on the reset edge itself
    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN) || (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b_load;
                        carry <= carry_load;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    carry <= c_bit;
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    sum   <= {s_bit, sum[WIDTH-1:1]};
                    if (cnt == CNT_LAST) begin
                        cout  <= c_bit;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: stimulus pushes hand-computed {cout,sum}, a monitor pops on handshake.
module tb_serial_add_ctrl;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub = 1'b0;
`endif

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    logic [WIDTH:0] exp_q[$];
    int hs_q[$];

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .cin(cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum(sum),
        .cout(cout),
        .busy(busy)
`ifdef SERIAL_ADD_SUB_EN
        ,
        .sub(sub)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // monitor: a handshake happens on the next posedge whenever out_valid && out_ready
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            logic [WIDTH:0] e;
            hs_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_result: got sum 0x%0h cout %0d with empty scoreboard", sum, cout);
            end else begin
                e = exp_q.pop_front();
                check("sum", {24'd0, sum}, {24'd0, e[WIDTH-1:0]});
                check("cout", {31'd0, cout}, {31'd0, e[WIDTH]});
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input logic vc,
                        input logic [WIDTH:0] e, input bit push, input bit keep);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            fails++;
            $display("FAIL accept_timeout: in_ready 0, required 1 within 200 cycles");
            return;
        end
        a = va;
        b = vb;
        cin = vc;
        in_valid = 1'b1;
        @(posedge clk);
        if (push) exp_q.push_back(e);
        #1;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 0);
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_sum", {24'd0, sum}, 0);
        check("rst_cout", {31'd0, cout}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", {31'd0, in_ready}, 1);

        // latency: out_valid exactly WIDTH cycles after accept, high for one cycle
        send(8'h00, 8'h00, 1'b0, 9'h000, 1, 0);
        for (int k = 1; k <= WIDTH; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("lat_out_valid", {31'd0, out_valid}, (k == WIDTH) ? 1 : 0);
            check("lat_busy", {31'd0, busy}, 1);
        end
        @(posedge clk);
        @(negedge clk);
        check("post_hs_in_ready", {31'd0, in_ready}, 1);
        check("post_hs_out_valid", {31'd0, out_valid}, 0);

        send(8'hFF, 8'h01, 1'b0, 9'h100, 1, 0);
        send(8'hA5, 8'h5A, 1'b1, 9'h100, 1, 0);
        send(8'h3C, 8'h0F, 1'b0, 9'h04B, 1, 0);
        drain();

        // backpressure: result held, new operands ignored
        out_ready = 1'b0;
        send(8'h80, 8'h80, 1'b1, 9'h101, 1, 0);
        begin
            int n = 0;
            @(negedge clk);
            while (!out_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", {31'd0, out_valid}, 1);
            check("bp_sum", {24'd0, sum}, 32'h01);
            check("bp_cout", {31'd0, cout}, 1);
            check("bp_in_ready", {31'd0, in_ready}, 0);
            a = 8'h11;
            b = 8'h22;
            in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();
        @(negedge clk);
        check("bp_not_captured_busy", {31'd0, busy}, 0);

        // reset while RUN with cnt==3
        send(8'h55, 8'h55, 1'b0, 9'h000, 0, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_out_valid", {31'd0, out_valid}, 0);
        check("midrst_busy", {31'd0, busy}, 0);
        check("midrst_sum", {24'd0, sum}, 0);
        check("midrst_cout", {31'd0, cout}, 0);
        check("midrst_in_ready", {31'd0, in_ready}, 0);
        rst = 1'b0;
        send(8'h12, 8'h34, 1'b0, 9'h046, 1, 0);
        drain();

        // back-to-back with in_valid and out_ready held high
        hs_q.delete();
        send(8'h01, 8'h02, 1'b0, 9'h003, 1, 1);
        send(8'hF0, 8'h20, 1'b0, 9'h110, 1, 1);
        send(8'h7F, 8'h7F, 1'b1, 9'h0FF, 1, 1);
        in_valid = 1'b0;
        drain();
        check("b2b_count", hs_q.size(), 3);
        if (hs_q.size() == 3) begin
            check("b2b_spacing1", hs_q[1] - hs_q[0], WIDTH + 2);
            check("b2b_spacing2", hs_q[2] - hs_q[1], WIDTH + 2);
        end

`ifdef SERIAL_ADD_SUB_EN
        sub = 1'b1;
        send(8'h10, 8'h01, 1'b0, 9'h10F, 1, 0);
        send(8'h00, 8'h01, 1'b0, 9'h0FF, 1, 0);
        drain();
        sub = 1'b0;
        send(8'h10, 8'h01, 1'b0, 9'h011, 1, 0);
        drain();
`endif

        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
